// File: rtl/poly1305_mac_core_if.sv
// Key/message/tag bus of the Poly1305 MAC core.
// The framer side is the master and the core is the slave.
interface poly1305_mac_core_if;
  logic         key_load;
  logic [127:0] key_r;
  logic [127:0] key_s;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic [4:0]   blk_len;
  logic         blk_last;
  logic         tag_valid;
  logic [127:0] tag;
  logic         busy;

  modport master (
    output key_load, key_r, key_s, blk_valid, blk_data, blk_len, blk_last,
    input  blk_ready, tag_valid, tag, busy
  );

  modport slave (
    input  key_load, key_r, key_s, blk_valid, blk_data, blk_len, blk_last,
    output blk_ready, tag_valid, tag, busy
  );
endinterface

// File: rtl/poly1305_mac_core.sv
// Multi-block Poly1305 MAC engine.
// Flow per block: h + m, then a digit-serial multiply by r (DIGIT_W bits of r
// per cycle), then a two-step partial reduction mod 2^130-5. After the last
// block, h is brought to its canonical value and the tag (h + s) mod 2^128
// is produced.
module poly1305_mac_core #(
  parameter int DIGIT_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  poly1305_mac_core_if.slave bus
);

  localparam int N_DIG = 128 / DIGIT_W;
  localparam int CNT_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_MUL,
    S_RED1,
    S_RED2,
    S_FINAL,
    S_TAG
  } state_t;

  state_t state_q, state_d;

  logic [127:0]       r_q;
  logic [127:0]       s_q;
  logic               key_ok_q;
  logic [129:0]       h_q;
  logic [127:0]       data_q;
  logic [4:0]         len_q;
  logic               last_q;
  logic [130:0]       a_q;
  logic [258:0]       prod_q;
  logic [132:0]       t_q;
  logic [CNT_W-1:0]   dig_q;
  logic [127:0]       tag_q;
  logic               tag_valid_q;

  logic               blk_ready_d;
  logic               busy_d;
  logic               key_take;
  logic               blk_fire;

  logic [4:0]         len_eff;
  logic [128:0]       m_pad;
  logic [130:0]       a_d;
  logic [7:0]         shamt;
  logic [DIGIT_W-1:0] r_dig;
  logic [130+DIGIT_W:0] pp;
  logic [258:0]       pp_sh;
  logic [132:0]       t_d;
  logic [129:0]       h_red;
  logic [130:0]       h_plus5;
  logic [129:0]       h_can;

  // A key is only taken while idle; a block only when a key is present and
  // no key_load competes for the same cycle.
  assign key_take = bus.key_load & (state_q == S_IDLE);
  assign blk_fire = bus.blk_valid & blk_ready_d;

  assign bus.blk_ready = blk_ready_d;
  assign bus.busy      = busy_d;
  assign bus.tag       = tag_q;
  assign bus.tag_valid = tag_valid_q;

  // Build the padded block: keep bytes below len, put the 0x01 pad just above.
  always_comb begin
    len_eff = (len_q == 5'd0) ? 5'd16 : len_q;
    m_pad   = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < len_eff) begin
        m_pad[8*i +: 8] = data_q[8*i +: 8];
      end
    end
    m_pad[{len_eff, 3'b000}] = 1'b1;
  end

  assign a_d = 131'(h_q) + 131'(m_pad);

  // One r digit per multiply cycle, weighted by its position in r.
  assign shamt = 8'(dig_q) * 8'(DIGIT_W);
  assign r_dig = r_q[shamt +: DIGIT_W];
  assign pp    = {{DIGIT_W{1'b0}}, a_q} * {131'd0, r_dig};
  assign pp_sh = 259'(pp) << shamt;

  // Fold bits above 2^130 back in with weight 5, twice, then the final
  // conditional subtraction of p.
  assign t_d     = 133'(prod_q[129:0]) + 133'(prod_q[258:130]) * 133'd5;
  assign h_red   = 130'(133'(t_q[129:0]) + 133'(t_q[132:130]) * 133'd5);
  assign h_plus5 = 131'(h_q) + 131'd5;
  assign h_can   = h_plus5[130] ? h_plus5[129:0] : h_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state sequencing and the handshake/status outputs.
  always_comb begin
    state_d     = state_q;
    blk_ready_d = 1'b0;
    busy_d      = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy_d      = 1'b0;
        blk_ready_d = key_ok_q & ~bus.key_load;
        if (bus.blk_valid & key_ok_q & ~bus.key_load) state_d = S_ADD;
      end
      S_ADD:   state_d = S_MUL;
      S_MUL:   if (dig_q == CNT_W'(N_DIG - 1)) state_d = S_RED1;
      S_RED1:  state_d = S_RED2;
      S_RED2:  state_d = last_q ? S_FINAL : S_IDLE;
      S_FINAL: state_d = S_TAG;
      S_TAG:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Key storage: r is clamped on capture, key_ok enables block acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q      <= '0;
      s_q      <= '0;
      key_ok_q <= 1'b0;
    end else if (key_take) begin
      r_q      <= bus.key_r & CLAMP;
      s_q      <= bus.key_s;
      key_ok_q <= 1'b1;
    end
  end

  // Accumulator h: zeroed by a new key or after a tag, updated by reduction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0;
    end else if (key_take || state_q == S_TAG) begin
      h_q <= '0;
    end else if (state_q == S_RED2) begin
      h_q <= h_red;
    end else if (state_q == S_FINAL) begin
      h_q <= h_can;
    end
  end

  // Latch the accepted block so the framer may move on immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      len_q  <= '0;
      last_q <= 1'b0;
    end else if (blk_fire) begin
      data_q <= bus.blk_data;
      len_q  <= bus.blk_len;
      last_q <= bus.blk_last;
    end
  end

  // Per-block arithmetic: add, digit-serial multiply, first fold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      prod_q <= '0;
      t_q    <= '0;
      dig_q  <= '0;
    end else begin
      case (state_q)
        S_ADD: begin
          a_q    <= a_d;
          prod_q <= '0;
          dig_q  <= '0;
        end
        S_MUL: begin
          prod_q <= prod_q + pp_sh;
          dig_q  <= dig_q + CNT_W'(1);
        end
        S_RED1: t_q <= t_d;
        default: ;
      endcase
    end
  end

  // Tag is captured together with the canonical h and held until the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
    end else begin
      tag_valid_q <= (state_q == S_FINAL);
      if (state_q == S_FINAL) tag_q <= h_can[127:0] + s_q;
    end
  end

endmodule

// File: tb/tb_poly1305_mac_core.sv
// Bench for poly1305_mac_core: three widths (32, 8, 128) driven one at a time,
// outputs compared every cycle against an arithmetic Poly1305 model.
module tb_poly1305_mac_core;

  localparam logic [259:0] CLAMP_M = 260'h0ffffffc0ffffffc0ffffffc0fffffff;
  localparam logic [127:0] RFC_R   = 128'ha806d542fe52447f336d555778bed685;
  localparam logic [127:0] RFC_S   = 128'h1bf54941aff6bf4afdb20dfb8a800301;
  localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;
  localparam logic [127:0] S4      = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] AA41    = 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaa41;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n   = 1'b0;
  logic         key_load  = 1'b0;
  logic [127:0] key_r     = '0;
  logic [127:0] key_s     = '0;
  logic         blk_valid = 1'b0;
  logic [127:0] blk_data  = '0;
  logic [4:0]   blk_len   = '0;
  logic         blk_last  = 1'b0;
  int           sel       = 0;

  poly1305_mac_core_if bus32();
  poly1305_mac_core_if bus8();
  poly1305_mac_core_if bus128();

  assign bus32.key_load  = key_load & (sel == 0);
  assign bus8.key_load   = key_load & (sel == 1);
  assign bus128.key_load = key_load & (sel == 2);
  assign bus32.blk_valid  = blk_valid & (sel == 0);
  assign bus8.blk_valid   = blk_valid & (sel == 1);
  assign bus128.blk_valid = blk_valid & (sel == 2);
  assign bus32.key_r = key_r;    assign bus8.key_r = key_r;    assign bus128.key_r = key_r;
  assign bus32.key_s = key_s;    assign bus8.key_s = key_s;    assign bus128.key_s = key_s;
  assign bus32.blk_data = blk_data; assign bus8.blk_data = blk_data; assign bus128.blk_data = blk_data;
  assign bus32.blk_len = blk_len;   assign bus8.blk_len = blk_len;   assign bus128.blk_len = blk_len;
  assign bus32.blk_last = blk_last; assign bus8.blk_last = blk_last; assign bus128.blk_last = blk_last;

  poly1305_mac_core #(.DIGIT_W(32))  dut32  (.clk(clk), .reset_n(reset_n), .bus(bus32));
  poly1305_mac_core #(.DIGIT_W(8))   dut8   (.clk(clk), .reset_n(reset_n), .bus(bus8));
  poly1305_mac_core #(.DIGIT_W(128)) dut128 (.clk(clk), .reset_n(reset_n), .bus(bus128));

  logic         dut_ready, dut_tag_valid, dut_busy;
  logic [127:0] dut_tag;

  always_comb begin
    dut_ready = bus32.blk_ready; dut_tag_valid = bus32.tag_valid;
    dut_busy  = bus32.busy;      dut_tag       = bus32.tag;
    if (sel == 1) begin
      dut_ready = bus8.blk_ready; dut_tag_valid = bus8.tag_valid;
      dut_busy  = bus8.busy;      dut_tag       = bus8.tag;
    end else if (sel == 2) begin
      dut_ready = bus128.blk_ready; dut_tag_valid = bus128.tag_valid;
      dut_busy  = bus128.busy;      dut_tag       = bus128.tag;
    end
  end

  // Model state: Poly1305 over integers, plus when the core should be busy.
  int           cyc = 0;
  int           busy_end = 0;
  int           tag_due = -1;
  logic         key_ok_m = 1'b0;
  logic [259:0] r_m = '0, s_m = '0, h_m = '0;
  logic [127:0] pend_tag = '0;
  logic [127:0] tag_hold = '0;
  int           checks = 0;
  int           errors = 0;
  string        rfc_msg = "Cryptographic Forum Research Group";

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int n_cur();
    return (sel == 1) ? 16 : (sel == 2) ? 1 : 4;
  endfunction

  function automatic logic [259:0] p_val();
    return (260'd1 << 130) - 260'd5;
  endfunction

  function automatic logic [259:0] pad_block(input logic [127:0] d, input logic [4:0] len);
    logic [259:0] m;
    int l;
    l = (len == 5'd0) ? 16 : int'(len);
    m = '0;
    for (int i = 0; i < l; i++) m[8*i +: 8] = d[8*i +: 8];
    m[8*l] = 1'b1;
    return m;
  endfunction

  function automatic logic [127:0] rfc_block(input int off);
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < 16; i++)
      if (off + i < rfc_msg.len()) d[8*i +: 8] = rfc_msg[off + i];
    return d;
  endfunction

  task automatic check_output(input string name, input logic [259:0] got, input logic [259:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Every cycle: status, handshake and tag outputs against the model.
  always @(negedge clk) begin
    if (!reset_n) tag_hold = '0;
    else if (cyc == tag_due) tag_hold = pend_tag;
    check_output("busy", 260'(dut_busy), 260'(cyc < busy_end));
    check_output("blk_ready", 260'(dut_ready), 260'(key_ok_m && (cyc >= busy_end) && !key_load));
    check_output("tag_valid", 260'(dut_tag_valid), 260'(cyc == tag_due));
    check_output("tag", 260'(dut_tag), 260'(tag_hold));
  end

  task automatic do_reset(input int new_sel);
    reset_n = 1'b0; key_load = 1'b0; blk_valid = 1'b0;
    sel = new_sel;
    busy_end = 0; tag_due = -1; key_ok_m = 1'b0; h_m = '0;
    @(negedge clk);
    check_output("rst_busy", 260'(dut_busy), 260'd0);
    check_output("rst_ready", 260'(dut_ready), 260'd0);
    check_output("rst_tag_valid", 260'(dut_tag_valid), 260'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic load_key(input logic [127:0] r, input logic [127:0] s, output int kc);
    int c;
    c = cyc;
    key_load = 1'b1; key_r = r; key_s = s;
    @(posedge clk); #1;
    key_load = 1'b0;
    kc = cyc;
    if (c >= busy_end) begin
      key_ok_m = 1'b1;
      r_m = 260'(r) & CLAMP_M;
      s_m = 260'(s);
      h_m = '0;
    end
  endtask

  // Offer one block, wait (bounded) for acceptance, advance the model.
  task automatic apply_stimulus(input logic [127:0] data, input logic [4:0] len,
                                input logic last, output int e);
    int  budget;
    bit  got;
    blk_valid = 1'b1; blk_data = data; blk_len = len; blk_last = last;
    budget = 200; got = 0; e = -1;
    while (!got && budget > 0) begin
      @(negedge clk);
      if (dut_ready) got = 1;
      else budget--;
    end
    if (!got) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: got blk_ready=0, expected 1 within 200 cycles");
      @(posedge clk); #1;
      blk_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e = cyc;
    h_m = ((h_m + pad_block(data, len)) * r_m) % p_val();
    if (last) begin
      pend_tag = 128'(h_m + s_m);
      tag_due  = e + n_cur() + 4;
      busy_end = e + n_cur() + 5;
      h_m = '0;
    end else begin
      busy_end = e + n_cur() + 3;
    end
    blk_valid = 1'b0;
    blk_data  = {$urandom, $urandom, $urandom, $urandom};
    blk_len   = 5'($urandom);
    blk_last  = 1'($urandom);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 300;
    while (cyc <= busy_end && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
  endtask

  task automatic send_rfc(output int e1, output int e2);
    int e3;
    apply_stimulus(rfc_block(0), 5'd16, 1'b0, e1);
    apply_stimulus(rfc_block(16), 5'd16, 1'b0, e2);
    apply_stimulus(rfc_block(32), 5'd2, 1'b1, e3);
    wait_idle();
  endtask

  task automatic check_tag(input string name, input logic [127:0] exp);
    check_output({name, "_dut"}, 260'(dut_tag), 260'(exp));
    check_output({name, "_model"}, 260'(pend_tag), 260'(exp));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e1, e2, e3, kc;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check_output("reset_tag", 260'(dut_tag), 260'd0);

    $display("[TB] block offered before any key");
    blk_valid = 1'b1; blk_data = AA41; blk_len = 5'd3; blk_last = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_output("ready_no_key", 260'(dut_ready), 260'd0);
    blk_valid = 1'b0;

    $display("[TB] RFC 8439 vector, DIGIT_W=32");
    load_key(RFC_R, RFC_S, kc);
    send_rfc(e1, e2);
    check_tag("rfc32", RFC_TAG);
    check_output("gap32", 260'(e2 - e1), 260'd8);

    $display("[TB] key_load together with blk_valid, then pad of a 1-byte block");
    blk_valid = 1'b1; blk_data = AA41; blk_len = 5'd1; blk_last = 1'b1;
    load_key(128'd1, 128'd0, kc);
    apply_stimulus(AA41, 5'd1, 1'b1, e1);
    check_output("fire_after_key", 260'(e1), 260'(kc + 1));
    wait_idle();
    check_tag("len1", 128'h141);

    apply_stimulus(AA41, 5'd0, 1'b1, e1);
    wait_idle();
    check_tag("len0", AA41);

    $display("[TB] canonical reduction");
    load_key(128'd1, 128'd0, kc);
    apply_stimulus({128{1'b1}}, 5'd16, 1'b0, e1);
    apply_stimulus({128{1'b1}}, 5'd16, 1'b1, e2);
    wait_idle();
    check_tag("canon", 128'h3);

    $display("[TB] r=0 key");
    load_key(128'd0, S4, kc);
    for (int i = 0; i < 3; i++)
      apply_stimulus({$urandom, $urandom, $urandom, $urandom}, 5'($urandom_range(1, 16)), 1'(i == 2), e1);
    wait_idle();
    check_tag("r0", S4);

    $display("[TB] key_load during multiply is ignored");
    load_key(RFC_R, RFC_S, kc);
    apply_stimulus(rfc_block(0), 5'd16, 1'b0, e1);
    @(posedge clk); #1; @(posedge clk); #1;
    load_key(128'h1, 128'hdead, kc);
    apply_stimulus(rfc_block(16), 5'd16, 1'b0, e2);
    apply_stimulus(rfc_block(32), 5'd2, 1'b1, e3);
    wait_idle();
    check_tag("midkey", RFC_TAG);

    $display("[TB] reset during multiply of block 2");
    load_key(128'h5, 128'h7, kc);
    apply_stimulus(rfc_block(0), 5'd16, 1'b0, e1);
    apply_stimulus(rfc_block(16), 5'd16, 1'b0, e2);
    @(posedge clk); #1; @(posedge clk); #1;
    do_reset(0);
    check_output("ready_after_rst", 260'(dut_ready), 260'd0);
    load_key(RFC_R, RFC_S, kc);
    send_rfc(e1, e2);
    check_tag("post_rst", RFC_TAG);

    $display("[TB] RFC vector, DIGIT_W=8");
    do_reset(1);
    load_key(RFC_R, RFC_S, kc);
    send_rfc(e1, e2);
    check_tag("rfc8", RFC_TAG);
    check_output("gap8", 260'(e2 - e1), 260'd20);

    $display("[TB] RFC vector, DIGIT_W=128");
    do_reset(2);
    load_key(RFC_R, RFC_S, kc);
    send_rfc(e1, e2);
    check_tag("rfc128", RFC_TAG);
    check_output("gap128", 260'(e2 - e1), 260'd5);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly1305_mac_core.md
Name: poly1305_mac_core

Overview:
Parametrised multi-block Poly1305 MAC engine. It loads a 256-bit one-time key (r, s) and clamps r internally. It accepts a stream of 1..16-byte message blocks over a valid/ready handshake and keeps the accumulator h across blocks. After the last block it performs the full canonical reduction mod p = 2^130-5 and emits the 128-bit tag. It sits between the message framer and the tag comparator, and uses a built-in iterative digit-serial multiplier.

Parameters:
DIGIT_W, 32, r digit width per multiply cycle; legal values 8, 16, 32, 64, 128 (must divide 128).
N_DIG, 128/DIGIT_W, derived; multiply cycles per block; not overridable.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
key_load  in  1  one-cycle pulse; captures key_r/key_s, clears h
key_r  in  128  r, little-endian integer, clamped internally
key_s  in  128  s, little-endian integer
blk_valid  in  1  block offered
blk_ready  out  1  core accepts block this cycle
blk_data  in  128  message bytes, byte i at bits [8i+7:8i]
blk_len  in  5  valid bytes 1..16; value 0 is treated as 16
blk_last  in  1  final block of the message
tag_valid  out  1  one-cycle pulse, tag valid
tag  out  128  (h + s) mod 2^128
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: blk_ready=0, tag_valid=0, tag=0, busy=0; h, r, s and key_ok are 0; state is IDLE. Reset mid-operation aborts the block and discards the key. The core stays unready until the next key_load.
- Clamp: r = key_r & 0x0ffffffc0ffffffc0ffffffc0fffffff.
- key_load is honoured only in IDLE, where it sets key_ok and zeroes h. It is ignored in every other state.
- blk_ready = (state==IDLE) & key_ok & ~key_load. A simultaneous key_load and blk_valid in IDLE resolves to key_load; no block is accepted that cycle.
- Handshake: a block transfers when blk_valid & blk_ready. blk_data, blk_len and blk_last are latched on that edge.
- Padded block (129 bits): m = bytes [0..len-1] of blk_data, with bytes >= len masked to 0, plus a 1 at bit 8*len.
- FSM: IDLE -> ADD -> MUL (N_DIG cycles) -> RED1 -> RED2 -> (IDLE | FINAL -> TAG -> IDLE).
- ADD (1 cycle): a = h + m. Widths: h < 2^130 and m <= 2^129, so a is 131 bits.
- MUL: cycle k adds a * r[k*DIGIT_W +: DIGIT_W] << (k*DIGIT_W) into a 259-bit product accumulator. The accumulator is cleared in ADD.
- RED1: t = prod[129:0] + 5*prod[258:130], 133 bits.
- RED2: h = t[129:0] + 5*t[132:130]; invariant h < 2^130. If blk_last=0, go to IDLE; otherwise go to FINAL.
- FINAL: if h+5 >= 2^130 then h = h+5-2^130 (i.e. h-p); otherwise h is unchanged.
- TAG: tag = (h+s)[127:0] is registered; tag_valid=1 for exactly this cycle; h is cleared and key_ok is kept. The same key can start a new message, which is the caller's responsibility; tag holds its value until the next TAG or reset.
- Latency:
  - Handshake edge at cycle 0; blk_ready is high again at cycle N_DIG+4, i.e. 8 for DIGIT_W=32.
  - For a last block, tag_valid is high at cycle N_DIG+5 and blk_ready returns at N_DIG+6.
- blk_valid held while unready: no effect; data may change freely.

Test Plan:
1. RFC 8439 §2.5.2: r=0x806d5400e52447c036d555408bed685, s=0x1bf54941aff6bf4afdb20dfb8a800301, "Cryptographic Forum Research Group" sent as blocks of len 16,16,2 (last on third) -> single tag_valid pulse, tag=0xa927010caf8b2bc2c6365130c11d06a8. Repeat with DIGIT_W=8 and 128 -> same tag; blk_ready gaps of 20 and 5 cycles respectively.
2. Canonical reduction: r=1, s=0, two 16-byte all-0xff blocks, second with blk_last=1 -> h=2^130-2 >= p, tag=0x3 (not 0xff..fe).
3. Masking/pad: r=1, s=0, one block blk_len=1, blk_data=0xAAAA..AA41, last -> tag=0x141. Same with blk_len=0 -> tag equals blk_data (pad at bit 128 dropped by the mod 2^128).
4. r=0 key, s=0x0123..ef, any 3-block message -> tag=s; tag_valid pulses exactly once.
5. Handshake corners: blk_valid high before any key_load -> blk_ready stays 0. key_load and blk_valid in the same IDLE cycle -> no transfer; block accepted next cycle. key_load during MUL -> ignored; tag matches the original key.
6. Reset: drop reset_n during MUL of block 2 -> blk_ready/tag_valid/busy go 0 immediately. After release with a new key_load, the full RFC message gives the correct tag with no residue from the aborted message.
